// File: rtl/lobinho_pkg.sv
// Shared phase codes for the lobinho game: used by the phase controller,
// the display and the vote logic.
package lobinho_pkg;

  localparam int W_FASE = 3;

  typedef enum logic [W_FASE-1:0] {
    OCIOSO   = 3'd0,
    NOITE    = 3'd1,
    DIA      = 3'd2,
    VOTACAO  = 3'd3,
    APURACAO = 3'd4
  } fase_e;

  // Phases in which players take turns, one at a time.
  function automatic logic fase_de_turno(input fase_e f);
    return (f == NOITE) || (f == VOTACAO);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear and count enable.
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (zera) begin
      q_d = '0;
    end else if (conta) begin
      q_d = (q_q == N'(M - 1)) ? '0 : q_q + 1'b1;
    end
  end

  // NOTE: sequential state is always written with <=; only always_comb uses =.
  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fase_controlador.sv
// Game phase sequencer: OCIOSO -> NOITE -> DIA -> VOTACAO -> APURACAO.
// Optional freeze input `pausa` exists only when FASE_PAUSA_EN is defined.
module fase_controlador
  import lobinho_pkg::*;
#(
  parameter int N_JOG    = 8,
  parameter int W_JOG    = 3,
  parameter int T_JOGADA = 1000,
  parameter int T_DIA    = 5000,
  parameter int W_T      = 13
) (
  input  logic              clock,
  input  logic              zera,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              fim_jogo,
`ifdef FASE_PAUSA_EN
  input  logic              pausa,
`endif
  output logic [W_FASE-1:0] fase,
  output logic [W_JOG-1:0]  jogador_atual,
  output logic              vez,
  output logic              timeout,
  output logic              fim_rodada
);

  localparam int T_MAX = (T_JOGADA > T_DIA) ? T_JOGADA : T_DIA;

  fase_e            estado_q, estado_d;
  logic [W_JOG-1:0] jog_q, jog_d;
  logic             vez_q, vez_d;
  logic             timeout_q, timeout_d;
  logic             fim_rodada_q, fim_rodada_d;

  logic [W_T-1:0]   timer;
  logic             timer_clr;
  logic             timer_en;
  logic             pausa_w;

`ifdef FASE_PAUSA_EN
  assign pausa_w = pausa;
`else
  assign pausa_w = 1'b0;
`endif

  contador_m #(
    .M (T_MAX),
    .N (W_T)
  ) u_timer (
    .clock (clock),
    .zera  (timer_clr),
    .conta (timer_en),
    .q     (timer)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    estado_d     = estado_q;
    jog_d        = jog_q;
    timeout_d    = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;

    if (!pausa_w) begin
      case (estado_q)
        OCIOSO: begin
          timer_clr = 1'b1;
          jog_d     = '0;
          if (iniciar) estado_d = NOITE;
        end
        NOITE, VOTACAO: begin
          if (jogada || (timer == W_T'(T_JOGADA - 1))) begin
            // jogada wins over a simultaneous expiry, so no timeout then
            timer_clr = 1'b1;
            timeout_d = !jogada;
            if (jog_q == W_JOG'(N_JOG - 1)) begin
              jog_d    = '0;
              estado_d = (estado_q == NOITE) ? DIA : APURACAO;
            end else begin
              jog_d = jog_q + 1'b1;
            end
          end else begin
            timer_en = 1'b1;
          end
        end
        DIA: begin
          if (timer == W_T'(T_DIA - 1)) begin
            timer_clr = 1'b1;
            estado_d  = VOTACAO;
          end else begin
            timer_en = 1'b1;
          end
        end
        APURACAO: begin
          timer_clr = 1'b1;
          jog_d     = '0;
          estado_d  = fim_jogo ? OCIOSO : NOITE;
        end
        default: begin
          timer_clr = 1'b1;
          jog_d     = '0;
          estado_d  = OCIOSO;
        end
      endcase
    end

    // Reset also clears the timer through the FSM clear path.
    if (zera) timer_clr = 1'b1;

    vez_d        = fase_de_turno(estado_d);
    fim_rodada_d = (estado_d == APURACAO) && (estado_q != APURACAO);
  end

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked branch.
  always_ff @(posedge clock) begin
    if (zera) begin
      estado_q     <= OCIOSO;
      jog_q        <= '0;
      vez_q        <= 1'b0;
      timeout_q    <= 1'b0;
      fim_rodada_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      jog_q        <= jog_d;
      vez_q        <= vez_d;
      timeout_q    <= timeout_d;
      fim_rodada_q <= fim_rodada_d;
    end
  end

  assign fase          = estado_q;
  assign jogador_atual = jog_q;
  assign vez           = vez_q;
  assign timeout       = timeout_q;
  assign fim_rodada    = fim_rodada_q;

endmodule

// File: tb/tb_fase_controlador.sv
// Directed bench for fase_controlador with N_JOG=3, T_JOGADA=4, T_DIA=6.
module tb_fase_controlador;
  import lobinho_pkg::*;

  localparam int N_JOG    = 3;
  localparam int W_JOG    = 2;
  localparam int T_JOGADA = 4;
  localparam int T_DIA    = 6;
  localparam int W_T      = 4;

  logic clock    = 1'b0;
  logic zera     = 1'b1;
  logic iniciar  = 1'b0;
  logic jogada   = 1'b0;
  logic fim_jogo = 1'b0;
`ifdef FASE_PAUSA_EN
  logic pausa    = 1'b0;
`endif

  logic [W_FASE-1:0] fase;
  logic [W_JOG-1:0]  jogador_atual;
  logic              vez;
  logic              timeout;
  logic              fim_rodada;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  fase_controlador #(
    .N_JOG    (N_JOG),
    .W_JOG    (W_JOG),
    .T_JOGADA (T_JOGADA),
    .T_DIA    (T_DIA),
    .W_T      (W_T)
  ) dut (
    .clock         (clock),
    .zera          (zera),
    .iniciar       (iniciar),
    .jogada        (jogada),
    .fim_jogo      (fim_jogo),
`ifdef FASE_PAUSA_EN
    .pausa         (pausa),
`endif
    .fase          (fase),
    .jogador_atual (jogador_atual),
    .vez           (vez),
    .timeout       (timeout),
    .fim_rodada    (fim_rodada)
  );

  typedef struct {
    logic       zera;
    logic       iniciar;
    logic       jogada;
    logic       fim_jogo;
    logic [2:0] fase;
    logic [1:0] jog;
    logic       vez;
    logic       t_out;
    logic       f_rod;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t v(input logic z, input logic i, input logic j, input logic f,
                             input logic [2:0] fa, input logic [1:0] jg,
                             input logic ve, input logic t, input logic r);
    vec_t x;
    x.zera = z; x.iniciar = i; x.jogada = j; x.fim_jogo = f;
    x.fase = fa; x.jog = jg; x.vez = ve; x.t_out = t; x.f_rod = r;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {fase, jogador_atual, vez, timeout, fim_rodada};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_idx[$];
    int dia_cnt;
    logic saw_vot;

    // Outputs listed are those visible after the edge that samples the inputs.
    tab.push_back(v(1,0,0,0, 0,0,0,0,0));           // reset
    tab.push_back(v(0,0,0,0, 0,0,0,0,0));
    tab.push_back(v(0,1,0,0, 1,0,1,0,0));           // start: NOITE, timer 0
    for (int k = 0; k < 3; k++) tab.push_back(v(0,0,0,0, 1,0,1,0,0));
    tab.push_back(v(0,0,0,0, 1,1,1,1,0));           // player 0 expires
    for (int k = 0; k < 3; k++) tab.push_back(v(0,0,0,0, 1,1,1,0,0));
    tab.push_back(v(0,0,0,0, 1,2,1,1,0));           // player 1 expires
    for (int k = 0; k < 3; k++) tab.push_back(v(0,0,0,0, 1,2,1,0,0));
    tab.push_back(v(0,0,0,0, 2,0,0,1,0));           // player 2 expires -> DIA
    for (int k = 0; k < 5; k++) tab.push_back(v(0,0,0,0, 2,0,0,0,0));
    tab.push_back(v(0,0,0,0, 3,0,1,0,0));           // DIA done -> VOTACAO
    for (int k = 0; k < 3; k++) tab.push_back(v(0,0,0,0, 3,0,1,0,0));
    tab.push_back(v(0,0,1,0, 3,1,1,0,0));           // jogada together with timer=3
    tab.push_back(v(0,0,1,0, 3,2,1,0,0));
    tab.push_back(v(0,0,1,0, 4,0,0,0,1));           // APURACAO
    tab.push_back(v(0,0,0,0, 1,0,1,0,0));           // fim_jogo=0 -> NOITE
    tab.push_back(v(0,0,0,0, 1,0,1,0,0));           // timer 1
    tab.push_back(v(0,0,1,0, 1,1,1,0,0));
    tab.push_back(v(0,0,0,0, 1,1,1,0,0));
    tab.push_back(v(0,0,1,0, 1,2,1,0,0));
    tab.push_back(v(0,0,0,0, 1,2,1,0,0));
    tab.push_back(v(0,0,1,0, 2,0,0,0,0));           // third jogada -> DIA
    tab.push_back(v(0,0,1,0, 2,0,0,0,0));           // jogada ignored in DIA
    tab.push_back(v(0,0,0,0, 2,0,0,0,0));
    tab.push_back(v(0,0,0,0, 2,0,0,0,0));           // timer 3
    tab.push_back(v(1,1,1,0, 0,0,0,0,0));           // zera beats everything
    tab.push_back(v(0,0,0,0, 0,0,0,0,0));
    tab.push_back(v(0,1,0,0, 1,0,1,0,0));           // restart at player 0
    tab.push_back(v(0,1,0,0, 1,0,1,0,0));           // iniciar ignored in NOITE
    tab.push_back(v(0,0,1,0, 1,1,1,0,0));
    tab.push_back(v(0,0,1,0, 1,2,1,0,0));
    tab.push_back(v(0,0,1,0, 2,0,0,0,0));
    for (int k = 0; k < 5; k++) tab.push_back(v(0,0,0,0, 2,0,0,0,0));
    tab.push_back(v(0,0,0,0, 3,0,1,0,0));
    tab.push_back(v(0,0,1,0, 3,1,1,0,0));
    tab.push_back(v(0,0,1,1, 3,2,1,0,0));
    tab.push_back(v(0,0,1,1, 4,0,0,0,1));
    tab.push_back(v(0,0,0,1, 0,0,0,0,0));           // fim_jogo=1 -> OCIOSO
    tab.push_back(v(0,0,1,0, 0,0,0,0,0));           // jogada ignored when idle

    for (int k = 0; k < tab.size(); k++) begin
      zera     = tab[k].zera;
      iniciar  = tab[k].iniciar;
      jogada   = tab[k].jogada;
      fim_jogo = tab[k].fim_jogo;
      tick();
      check($sformatf("vec%0d {fase,jog,vez,timeout,fim_rodada}", k), 32'(outs()),
            32'({tab[k].fase, tab[k].jog, tab[k].vez, tab[k].t_out, tab[k].f_rod}));
    end
    zera = 0; iniciar = 0; jogada = 0; fim_jogo = 0;

    // Unattended night: timeout spacing and day length, measured in cycles.
    zera = 1; tick(); zera = 0;
    iniciar = 1; tick(); iniciar = 0;
    dia_cnt = 0;
    saw_vot = 1'b0;
    for (int cyc = 1; cyc <= 40 && !saw_vot; cyc++) begin
      tick();
      if (timeout) t_idx.push_back(cyc);
      if (fase == 3'd2) dia_cnt++;
      if (fase == 3'd3) saw_vot = 1'b1;
    end
    check("seq_timeout_count", t_idx.size(), 3);
    if (t_idx.size() == 3) begin
      check("seq_first_timeout", t_idx[0], 4);
      check("seq_gap_0_1", t_idx[1] - t_idx[0], 4);
      check("seq_gap_1_2", t_idx[2] - t_idx[1], 4);
    end
    check("seq_dia_length", dia_cnt, 6);
    check("seq_reached_votacao", 32'(saw_vot), 1);

`ifdef FASE_PAUSA_EN
    zera = 1; tick(); zera = 0;
    iniciar = 1; tick(); iniciar = 0;
    tick(); tick();                                   // timer now 2
    pausa = 1;
    for (int k = 0; k < 10; k++) begin
      jogada  = (k == 5);
      iniciar = (k == 3);
      tick();
      check($sformatf("pausa_hold%0d", k), 32'(outs()), 32'({3'd1, 2'd0, 1'b1, 1'b0, 1'b0}));
    end
    jogada = 0; iniciar = 0; pausa = 0;
    tick();
    check("pausa_release_1", 32'({timeout, jogador_atual}), 32'({1'b0, 2'd0}));
    tick();
    check("pausa_expire", 32'({timeout, jogador_atual}), 32'({1'b1, 2'd1}));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fase_controlador.md
FASE_CONTROLADOR -- requirements
Module: fase_controlador

Interface
- REQ-001 SHALL have parameter N_JOG, default 8: number of players polled per phase.
- REQ-002 SHALL have parameter W_JOG, default 3: width of the player index.
- REQ-003 SHALL have parameter T_JOGADA, default 1000: per-player turn limit, in clock cycles.
- REQ-004 SHALL have parameter T_DIA, default 5000: day-phase duration, in clock cycles.
- REQ-005 SHALL have parameter W_T, default 13: timer width, wide enough for max(T_JOGADA, T_DIA)-1.
- REQ-006 SHALL have one clock and a synchronous, active-high reset: ports `clock` and `zera`.
- REQ-007 SHALL have port `clock`, input, 1 bit: the single clock, rising edge.
- REQ-008 SHALL have port `zera`, input, 1 bit: synchronous active-high reset.
- REQ-009 SHALL have port `iniciar`, input, 1 bit: start-game pulse.
- REQ-010 SHALL have port `jogada`, input, 1 bit: current player confirms action, one-cycle pulse.
- REQ-011 SHALL have port `fim_jogo`, input, 1 bit: game-over flag, sampled in APURACAO.
- REQ-012 SHALL have port `fase`, output, 3 bits: current phase code.
- REQ-013 SHALL have port `jogador_atual`, output, W_JOG bits: index of the player whose turn it is.
- REQ-014 SHALL have port `vez`, output, 1 bit: high while jogador_atual awaits an action.
- REQ-015 SHALL have port `timeout`, output, 1 bit: one-cycle pulse when a turn expires without jogada.
- REQ-016 SHALL have port `fim_rodada`, output, 1 bit: one-cycle pulse when a round completes.

Function
- REQ-017 SHALL implement the FSM states OCIOSO=0, NOITE=1, DIA=2, VOTACAO=3, APURACAO=4; `fase` equals the state code, registered.
- REQ-018 SHALL move from OCIOSO to NOITE on `iniciar`, with jogador_atual=0 and timer=0; `iniciar` is ignored in every other state.
- REQ-019 In NOITE and VOTACAO, SHALL hold `vez`=1 and increment the timer every cycle.
- REQ-020 SHALL end a turn on `jogada`, or on timer==T_JOGADA-1, whichever comes first, by clearing the timer and incrementing jogador_atual on the next edge.
- REQ-021 SHALL pulse `timeout` in the ending cycle only when a turn ends by expiry without `jogada`; if `jogada` and expiry coincide, `jogada` wins and `timeout` stays 0.
- REQ-022 SHALL, when the turn of player N_JOG-1 ends, wrap jogador_atual to 0 and go NOITE->DIA or VOTACAO->APURACAO.
- REQ-023 In DIA, SHALL hold `vez`=0, ignore `jogada`, and go to VOTACAO at timer==T_DIA-1 with the timer cleared.
- REQ-024 SHALL make APURACAO last exactly one cycle with `fim_rodada`=1, then go to OCIOSO if `fim_jogo`=1, else to NOITE.
- REQ-025 SHALL keep the timer and jogador_atual at 0 in OCIOSO and APURACAO.
- REQ-026 SHALL register all outputs, with no combinational path from input to output.

Reset
- REQ-027 SHALL, on `zera`=1 at a clock edge, set state=OCIOSO, fase=0, jogador_atual=0, timer=0, vez=0, timeout=0 and fim_rodada=0.
- REQ-028 SHALL let `zera` mid-phase abort the round with no `timeout` or `fim_rodada` pulse; `zera` has priority over every other input.

Configuration
- REQ-029 SHALL, with macro FASE_PAUSA_EN defined, add input `pausa` (1 bit); while `pausa`=1 the timer, jogador_atual and state freeze, and `jogada`, `timeout` and `iniciar` are suppressed.
- REQ-030 SHALL, without FASE_PAUSA_EN, have no `pausa` port, with behaviour identical to `pausa`=0.

Structure
- REQ-031 SHALL put the phase codes (OCIOSO..APURACAO) and the 3-bit phase width in a shared package, `lobinho_pkg`, reused by display and vote logic.
- REQ-032 SHALL implement the turn/day timer with one instance of the existing `contador_m` sub-module (M=max(T_JOGADA, T_DIA), N=W_T), whose `zera` input is driven by FSM clear logic, not by the block reset.

Verification (N_JOG=3, T_JOGADA=4, T_DIA=6)
- REQ-033 SHALL check: `iniciar`, no `jogada` -> three `timeout` pulses 4 cycles apart, then fase=2 for 6 cycles, then fase=3.
- REQ-034 SHALL check: in NOITE, `jogada` at timer=1 for each player -> jogador_atual 0->1->2->0, no `timeout`, fase=2 after the 3rd jogada.
- REQ-035 SHALL check: `jogada` on the same cycle as timer=3 -> turn advances, `timeout`=0.
- REQ-036 SHALL check: VOTACAO completes with `fim_jogo`=0 -> one-cycle `fim_rodada`, fase 4->1; with `fim_jogo`=1 -> fase 4->0.
- REQ-037 SHALL check: `zera` during DIA at timer=3 -> next cycle all outputs 0 and fase=0; a later `iniciar` restarts at player 0.
- REQ-038 SHALL check, with FASE_PAUSA_EN: `pausa` held 10 cycles at timer=2 -> timer stays 2 with no `timeout`, and resumes to expire 2 cycles after release.
